// File: rtl/ov7670_pkg.sv
// Shared defaults and the frame-controller state encoding for the OV7670 capture path.
package ov7670_pkg;

  localparam int DEF_FRAME_PIXELS = 307200;
  localparam int DEF_ADDR_W       = 19;
  localparam int DEF_CNT_W        = 16;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, CHECK} frame_state_t;

endpackage

// File: rtl/ov7670_vsync_edge.sv
// Registers camera vsync and flags its rising and falling edges.
module ov7670_vsync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic vs_rise,
  output logic vs_fall
);

  logic vs_q;

  // Resets high so a camera already in blanking does not produce a false fall.
  always_ff @(posedge clk) begin
    if (!rst_n) vs_q <= 1'b1;
    else        vs_q <= vsync;
  end

  assign vs_rise = vsync & ~vs_q;
  assign vs_fall = ~vsync & vs_q;

endmodule

// File: rtl/ov7670_frame_ctrl.sv
// Frame-level gate between the capture block and the double-banked frame buffer:
// picks frames to write, validates their length and flips banks on good frames.
module ov7670_frame_ctrl
  import ov7670_pkg::*;
#(
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              sw,
  input  logic              mode,
  input  logic              snap,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [1:0]        cap_we,
  input  logic [7:0]        cap_dout,
  output logic [ADDR_W:0]   fb_addr,
  output logic [7:0]        fb_din,
  output logic [1:0]        fb_we,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [ADDR_W-1:0] FRAME_PIXELS_W = ADDR_W'(FRAME_PIXELS);

  frame_state_t      state, state_next;
  logic              vs_rise, vs_fall;
  logic [ADDR_W-1:0] pix_cnt;
  logic              good_frame;
  logic              capturing;
  logic              commit;
  logic              discard;

  ov7670_vsync_edge u_vsync_edge (
    .clk     (pclk),
    .rst_n   (rst_n),
    .vsync   (vsync),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall)
  );

  assign good_frame = (pix_cnt == FRAME_PIXELS_W);

  always_ff @(posedge pclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sw && (!mode || snap)) state_next = ARMED;
      ARMED: begin
        if (!sw)          state_next = IDLE;
        else if (vs_fall) state_next = CAPTURE;
      end
      CAPTURE: if (vs_rise) state_next = CHECK;
      // A bad frame keeps retrying in either mode; only a good one ends single-shot.
      CHECK: begin
        if (!sw)                   state_next = IDLE;
        else if (good_frame && mode) state_next = IDLE;
        else                       state_next = ARMED;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    capturing = (state == CAPTURE);
    commit    = (state == CHECK) && good_frame;
    discard   = (state == CHECK) && !good_frame;
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      fb_addr <= '0;
      fb_din  <= '0;
      fb_we   <= '0;
    end else begin
      fb_addr <= {wr_bank, cap_addr};
      fb_din  <= cap_dout;
      fb_we   <= capturing ? cap_we : 2'b00;
    end
  end

  // Counts second bytes, so one increment per completed pixel; saturates so long frames stay bad.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      pix_cnt <= '0;
    end else if (state == ARMED && vs_fall) begin
      pix_cnt <= '0;
    end else if (capturing && cap_we[0] && (pix_cnt != '1)) begin
      pix_cnt <= pix_cnt + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= commit;
      frame_err  <= discard;
      if (commit) begin
        wr_bank   <= ~wr_bank;
        rd_bank   <= wr_bank;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// Directed bench for ov7670_frame_ctrl using a short frame length to keep runs small.
module tb_ov7670_frame_ctrl;

  localparam int FP     = 20;
  localparam int ADDR_W = 19;
  localparam int CNT_W  = 16;

  logic              pclk;
  logic              rst_n;
  logic              vsync;
  logic              sw;
  logic              mode;
  logic              snap;
  logic [ADDR_W-1:0] cap_addr;
  logic [1:0]        cap_we;
  logic [7:0]        cap_dout;
  logic [ADDR_W:0]   fb_addr;
  logic [7:0]        fb_din;
  logic [1:0]        fb_we;
  logic              wr_bank;
  logic              rd_bank;
  logic              busy;
  logic              frame_done;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_cnt;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int we_seen  = 0;
  int excl_bad = 0;
  int bank_bad = 0;

  ov7670_frame_ctrl #(
    .FRAME_PIXELS (FP),
    .ADDR_W       (ADDR_W),
    .CNT_W        (CNT_W)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .sw         (sw),
    .mode       (mode),
    .snap       (snap),
    .cap_addr   (cap_addr),
    .cap_we     (cap_we),
    .cap_dout   (cap_dout),
    .fb_addr    (fb_addr),
    .fb_din     (fb_din),
    .fb_we      (fb_we),
    .wr_bank    (wr_bank),
    .rd_bank    (rd_bank),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (rst_n) begin
      done_cnt <= done_cnt + int'(frame_done);
      err_cnt  <= err_cnt + int'(frame_err);
      if (fb_we != 2'b00)            we_seen  <= we_seen + 1;
      if (frame_done && frame_err)   excl_bad <= excl_bad + 1;
    end
    if (rd_bank !== ~wr_bank) bank_bad <= bank_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_frame(input int n, input bit snap_mid);
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < n; i++) begin
      cap_we   = 2'b11;
      cap_addr = ADDR_W'(i);
      cap_dout = 8'(i);
      if (snap_mid && i == n / 2) snap = 1'b1;
      tick();
      snap = 1'b0;
    end
    cap_we = 2'b00;
    vsync  = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    int d0, e0, w0;
    rst_n = 1'b0; vsync = 1'b1; sw = 1'b0; mode = 1'b0; snap = 1'b0;
    cap_addr = ADDR_W'(7); cap_we = 2'b11; cap_dout = 8'h3C;
    repeat (2) tick();
    chk("rst_busy",    32'(busy),       32'd0);
    chk("rst_fb_we",   32'(fb_we),      32'd0);
    chk("rst_fb_addr", 32'(fb_addr),    32'd0);
    chk("rst_fb_din",  32'(fb_din),     32'd0);
    chk("rst_wr_bank", 32'(wr_bank),    32'd0);
    chk("rst_rd_bank", 32'(rd_bank),    32'd1);
    chk("rst_cnt",     32'(frame_cnt),  32'd0);
    chk("rst_done",    32'(frame_done), 32'd0);

    cap_we = 2'b00;
    rst_n = 1'b1; sw = 1'b1;
    tick();
    chk("cont_armed_busy", 32'(busy), 32'd1);

    // Three good frames in continuous mode: banks 0->1->0->1.
    for (int f = 0; f < 3; f++) begin
      send_frame(FP, 1'b0);
      chk($sformatf("cont_wr_bank_f%0d", f), 32'(wr_bank), (f % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("cont_done_cnt", 32'(done_cnt),  32'd3);
    chk("cont_err_cnt",  32'(err_cnt),   32'd0);
    chk("cont_frame_cnt", 32'(frame_cnt), 32'd3);

    sw = 1'b0;
    tick();
    chk("sw_off_idle", 32'(busy), 32'd0);

    // Enable mid-frame: nothing is written until the next full frame.
    vsync = 1'b0;
    repeat (3) tick();
    w0 = we_seen;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) sw = 1'b1;
      cap_we = 2'b11; cap_addr = ADDR_W'(i);
      tick();
    end
    cap_we = 2'b00; vsync = 1'b1;
    repeat (3) tick();
    chk("mid_no_we",    32'(we_seen - w0), 32'd0);
    chk("mid_armed",    32'(busy),         32'd1);
    d0 = done_cnt;
    send_frame(FP, 1'b0);
    chk("mid_done",     32'(done_cnt - d0), 32'd1);
    chk("mid_cnt",      32'(frame_cnt),     32'd4);
    chk("mid_wr_bank",  32'(wr_bank),       32'd0);

    // Short and long frames are discarded.
    d0 = done_cnt; e0 = err_cnt;
    send_frame(FP - 1, 1'b0);
    chk("short_err",     32'(err_cnt - e0), 32'd1);
    chk("short_wr_bank", 32'(wr_bank),      32'd0);
    chk("short_cnt",     32'(frame_cnt),    32'd4);
    send_frame(FP + 1, 1'b0);
    chk("long_err",      32'(err_cnt - e0), 32'd2);
    chk("long_wr_bank",  32'(wr_bank),      32'd0);
    chk("long_cnt",      32'(frame_cnt),    32'd4);
    chk("bad_no_done",   32'(done_cnt - d0), 32'd0);

    sw = 1'b0;
    tick();

    // Single-shot: waits for snap, commits one frame, then idles.
    mode = 1'b1; sw = 1'b1;
    repeat (2) tick();
    chk("ss_wait_snap", 32'(busy), 32'd0);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("ss_armed", 32'(busy), 32'd1);
    d0 = done_cnt;
    send_frame(FP, 1'b1);
    chk("ss_done1",   32'(done_cnt - d0), 32'd1);
    chk("ss_cnt",     32'(frame_cnt),     32'd5);
    chk("ss_wr_bank", 32'(wr_bank),       32'd1);
    chk("ss_idle",    32'(busy),          32'd0);
    w0 = we_seen;
    send_frame(FP, 1'b0);
    chk("ss_no_we",   32'(we_seen - w0),  32'd0);
    chk("ss_done2",   32'(done_cnt - d0), 32'd1);
    chk("ss_fb_we",   32'(fb_we),         32'd0);

    // Gating in ARMED, then one-cycle latency in CAPTURE.
    mode = 1'b0;
    tick();
    cap_we = 2'b10; cap_addr = ADDR_W'(5); cap_dout = 8'hA5;
    tick();
    chk("armed_gate", 32'(fb_we), 32'd0);
    cap_we = 2'b00; vsync = 1'b0;
    tick();
    cap_we = 2'b10; cap_addr = ADDR_W'(5); cap_dout = 8'hA5;
    tick();
    chk("lat_fb_we",   32'(fb_we),   32'd2);
    chk("lat_fb_addr", 32'(fb_addr), 32'h80005);
    chk("lat_fb_din",  32'(fb_din),  32'hA5);

    // Reset in the middle of a capture.
    cap_we = 2'b11;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy",    32'(busy),       32'd0);
    chk("mrst_fb_we",   32'(fb_we),      32'd0);
    chk("mrst_wr_bank", 32'(wr_bank),    32'd0);
    chk("mrst_rd_bank", 32'(rd_bank),    32'd1);
    chk("mrst_cnt",     32'(frame_cnt),  32'd0);
    chk("mrst_done",    32'(frame_done), 32'd0);
    chk("mrst_err",     32'(frame_err),  32'd0);
    cap_we = 2'b00;
    repeat (2) tick();

    chk("pulse_exclusive", 32'(excl_bad), 32'd0);
    chk("rd_bank_inverse", 32'(bank_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov7670_frame_ctrl.md
# ov7670_frame_ctrl

Frame-level controller for the OV7670 capture path. It sits between the capture block's byte-write outputs and the double-banked frame buffer. It decides which frames are written, into which bank, and when the display side may switch to the newly completed bank. It supports continuous capture and single-shot snapshot, and rejects short or long frames.

## Interface
Parameters:
- FRAME_PIXELS, 307200: pixels per valid frame (640x480, one pixel = two bytes).
- ADDR_W, 19: capture pixel-address width.
- CNT_W, 16: frame counter width.

Ports:
- pclk  in  1  camera pixel clock; sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- vsync  in  1  camera vsync; high = vertical blanking.
- sw  in  1  capture enable; 0 = arm no new frames.
- mode  in  1  0 = continuous, 1 = single-shot.
- snap  in  1  one-cycle snapshot request (single-shot mode only).
- cap_addr  in  ADDR_W  pixel address from capture block.
- cap_we  in  2  byte write enables from capture block; [1] = first byte, [0] = second byte of a pixel.
- cap_dout  in  8  byte data from capture block.
- fb_addr  out  ADDR_W+1  frame-buffer address: {wr_bank, cap_addr}, registered.
- fb_din  out  8  cap_dout delayed one cycle.
- fb_we  out  2  gated cap_we, registered.
- wr_bank  out  1  bank being written.
- rd_bank  out  1  bank the display reads; always ~wr_bank.
- busy  out  1  state is ARMED, CAPTURE or CHECK.
- frame_done  out  1  one-cycle pulse: good frame committed.
- frame_err  out  1  one-cycle pulse: frame discarded.
- frame_cnt  out  CNT_W  count of committed frames, wraps.

## Operation
- Edge detect: vs_q <= vsync each cycle.
  - vs_fall = ~vsync & vs_q.
  - vs_rise = vsync & ~vs_q.
- IDLE: fb_we = 0.
  - Continuous mode with sw=1: go to ARMED.
  - Single-shot mode with snap=1 and sw=1: go to ARMED.
- ARMED: wait for vs_fall, then clear pix_cnt and go to CAPTURE.
  - Capture always starts on a frame boundary; partial frames are never written.
  - sw=0 in ARMED: return to IDLE.
- CAPTURE: fb_we <= cap_we (registered); outside CAPTURE, fb_we <= 0.
  - pix_cnt increments on each cycle with cap_we[0]=1.
  - pix_cnt saturates at 2^ADDR_W-1.
  - On vs_rise, go to CHECK.
  - sw changes are ignored until CHECK.
- CHECK (one cycle):
  - If pix_cnt == FRAME_PIXELS: wr_bank <= ~wr_bank, rd_bank <= wr_bank, frame_cnt +1, frame_done pulse.
  - Otherwise: frame_err pulse, banks unchanged, frame_cnt unchanged; the bank is reused.
- Next state after CHECK:
  - Good frame, single-shot mode: IDLE.
  - Good frame, continuous mode with sw=1: ARMED.
  - Bad frame with sw=1, either mode: ARMED (single-shot retries until it gets a good frame).
  - sw=0 in any case: IDLE.
- Precedence:
  - snap outside IDLE is ignored.
  - mode is sampled only in IDLE and CHECK.
- Reset values:
  - state IDLE, vs_q 1, pix_cnt 0, wr_bank 0, rd_bank 1.
  - fb_we 0, fb_addr 0, fb_din 0.
  - frame_done 0, frame_err 0, frame_cnt 0, busy 0.
- Reset mid-frame abandons the frame. Bank selection restarts from wr_bank=0.

## Timing
- Datapath latency: fb_addr, fb_din and fb_we lag cap_addr, cap_dout and cap_we by exactly 1 pclk.
- fb_addr MSB is the wr_bank value at the sampling edge. wr_bank never changes during CAPTURE.
- Edge k: vsync rises; vs_rise is asserted in the cycle before edge k+1.
  - Edge k+1: state becomes CHECK.
  - Edge k+2: banks, frame_cnt and frame_done or frame_err update.
  - Edge k+3: the pulse clears.
- frame_done and frame_err are mutually exclusive and exactly one cycle wide.
- A cap_we[0] in the vs_rise cycle still counts.
- Continuous mode: if vsync falls within 2 cycles of its rise, that frame is missed (ARMED is entered after the fall). This is accepted; the camera's vsync is far longer.
- frame_cnt wraps from 2^CNT_W-1 to 0.

## Structure
- Package ov7670_pkg holds:
  - FRAME_PIXELS, ADDR_W, CNT_W defaults.
  - typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, CHECK} frame_state_t.
- One sub-module, ov7670_vsync_edge: the vs_q register plus the rise/fall outputs, reset value 1. Everything else stays in ov7670_frame_ctrl.

## Test plan
- Reset, then mode=0, sw=1; drive 3 frames of 307200 cap_we[0] pulses between vsync pulses.
  - frame_done 3 times, no frame_err, frame_cnt=3.
  - wr_bank sequence 0→1→0→1; rd_bank always ~wr_bank.
- Assert sw=1 mid-frame (vsync low).
  - No fb_we until after the next vsync fall.
  - The first frame counted is a full 307200-pixel frame, so frame_done follows.
- Drive a frame of 307199 pixels, then one of 307201.
  - frame_err each time; wr_bank and frame_cnt unchanged.
- Single-shot: mode=1, snap pulse in IDLE, 2 good frames follow.
  - Exactly 1 frame_done, then IDLE with fb_we=0.
  - A snap during CAPTURE has no effect.
- Assert rst_n=0 for one edge mid-CAPTURE.
  - Next cycle: state IDLE, fb_we=0, wr_bank=0, rd_bank=1, frame_cnt=0, no pulses.
- Check latency and gating: cap_we=2'b10 with cap_addr=5 at edge n.
  - fb_we=2'b10 and fb_addr={wr_bank,19'd5} at edge n+1.
  - Same stimulus in ARMED gives fb_we=0.
